// File: rtl/ca_seq_52bit.sv
// 52x52 carry-less (GF(2)) multiplier built from one 13x13 carry-less core that is
// reused over the 16 segment pairs, one pair per clock. Result is the unreduced 103-bit product.

module ca_13bit (
   input  logic [12:0] a,
   input  logic [12:0] b,
   output logic [24:0] p
);

   function automatic logic [24:0] clmul13(input logic [12:0] x, input logic [12:0] z);
      logic [24:0] r;
      r = '0;
      for (int k = 0; k < 13; k++) begin
         if (z[k]) begin
            r = r ^ ({12'd0, x} << k);
         end
      end
      return r;
   endfunction

   always_comb begin
      p = clmul13(a, b);
   end

endmodule

module ca_seq_52bit (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [51:0]  a,
   input  logic [51:0]  b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [102:0] y,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [51:0]    a_reg_q, a_reg_d;
   logic [51:0]    b_reg_q, b_reg_d;
   logic [102:0]   acc_q, acc_d;
   logic [3:0]     cnt_q, cnt_d;

   logic [1:0]     seg_i, seg_j;
   logic [2:0]     seg_k;
   logic [12:0]    seg_a, seg_b;
   logic [24:0]    part;

   function automatic logic [12:0] seg_sel(input logic [51:0] v, input logic [1:0] idx);
      logic [12:0] s;
      case (idx)
         2'd0:    s = v[12:0];
         2'd1:    s = v[25:13];
         2'd2:    s = v[38:26];
         default: s = v[51:39];
      endcase
      return s;
   endfunction

   // Partial product lands at bit 13*(i+j); widest placement (k=6) tops out at bit 102.
   function automatic logic [102:0] place(input logic [24:0] p, input logic [2:0] k);
      logic [102:0] w;
      w = {78'd0, p};
      case (k)
         3'd0:    place = w;
         3'd1:    place = w << 13;
         3'd2:    place = w << 26;
         3'd3:    place = w << 39;
         3'd4:    place = w << 52;
         3'd5:    place = w << 65;
         3'd6:    place = w << 78;
         default: place = '0;
      endcase
   endfunction

   assign seg_i = cnt_q[3:2];
   assign seg_j = cnt_q[1:0];
   assign seg_k = {1'b0, seg_i} + {1'b0, seg_j};
   assign seg_a = seg_sel(a_reg_q, seg_i);
   assign seg_b = seg_sel(b_reg_q, seg_j);

   ca_13bit u_core (
      .a (seg_a),
      .b (seg_b),
      .p (part)
   );

   always_comb begin
      state_d   = state_q;
      a_reg_d   = a_reg_q;
      b_reg_d   = b_reg_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               a_reg_d = a;
               b_reg_d = b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MUL;
            end
         end
         MUL: begin
            busy  = 1'b1;
            acc_d = acc_q ^ place(part, seg_k);
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               state_d = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_reg_q <= '0;
         b_reg_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_reg_q <= a_reg_d;
         b_reg_q <= b_reg_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign y = acc_q;

endmodule

// File: tb/tb_ca_seq_52bit.sv
// Directed and random checks for the sequential 52x52 carry-less multiplier.

module tb_ca_seq_52bit;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [51:0]  a;
   logic [51:0]  b;
   logic         out_valid;
   logic         out_ready;
   logic [102:0] y;
   logic         busy;

   int tests;
   int fails;

   ca_seq_52bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   // Plain bit-by-bit reference, independent of the segmented datapath.
   function automatic logic [102:0] clmul_ref(input logic [51:0] x, input logic [51:0] z);
      logic [102:0] r;
      r = '0;
      for (int i = 0; i < 52; i++) begin
         for (int j = 0; j < 52; j++) begin
            if (x[i] && z[j]) begin
               r[i+j] = ~r[i+j];
            end
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_accept(input logic [51:0] av, input logic [51:0] bv);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      in_valid = 1'b1;
      a = av;
      b = bv;
      tick();
      in_valid = 1'b0;
      a = 52'({$urandom(), $urandom()});
      b = 52'({$urandom(), $urandom()});
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      if (!out_valid) lat = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      #3 rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || y !== 103'd0) begin
         fails++;
         $display("FAIL reset_state: out_valid=%b busy=%b y=%h, expected 0 0 0", out_valid, busy, y);
      end
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tests++;
      if (in_ready !== 1'b1) begin
         fails++;
         $display("FAIL reset_in_ready: in_ready=%b, expected 1", in_ready);
      end
   endtask

   task automatic test_unit();
      int k;
      int lat;
      logic [102:0] yv;
      out_ready = 1'b1;
      do_accept(52'd1, 52'd1);
      k = 0;
      lat = -1;
      yv = '0;
      while (busy && k < 40) begin
         if (out_valid && lat < 0) begin
            lat = k;
            yv = y;
         end
         k++;
         tick();
      end
      tests++;
      if (lat != 16) begin
         fails++;
         $display("FAIL unit_latency: got %0d, expected 16", lat);
      end
      tests++;
      if (yv !== 103'd1) begin
         fails++;
         $display("FAIL unit_y: got %h, expected 1", yv);
      end
      tests++;
      if (k != 17) begin
         fails++;
         $display("FAIL unit_busy_cycles: got %0d, expected 17", k);
      end
      tests++;
      if (y !== 103'd1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL unit_after_done: y=%h out_valid=%b, expected 1 0", y, out_valid);
      end
   endtask

   task automatic test_product(input string name, input logic [51:0] av, input logic [51:0] bv,
                               input logic [102:0] exp);
      int lat;
      out_ready = 1'b1;
      do_accept(av, bv);
      wait_done(lat);
      tests++;
      if (lat != 16) begin
         fails++;
         $display("FAIL %s_latency: got %0d, expected 16", name, lat);
      end
      tests++;
      if (y !== exp) begin
         fails++;
         $display("FAIL %s_y: got %h, expected %h", name, y, exp);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int lat;
      logic [102:0] exp;
      logic ok;
      exp = 103'h1555555;
      out_ready = 1'b0;
      do_accept(52'h1FFF, 52'h1FFF);
      for (int n = 0; n < 5; n++) tick();
      tests++;
      if (in_ready !== 1'b0) begin
         fails++;
         $display("FAIL bp_in_ready_mul: got %b, expected 0", in_ready);
      end
      in_valid = 1'b1;
      a = {52{1'b1}};
      b = {52{1'b1}};
      tick();
      in_valid = 1'b0;
      wait_done(lat);
      tests++;
      if (lat != 10) begin
         fails++;
         $display("FAIL bp_latency: got %0d, expected 10", lat);
      end
      ok = 1'b1;
      for (int n = 0; n < 5; n++) begin
         if (out_valid !== 1'b1 || y !== exp || in_ready !== 1'b0) ok = 1'b0;
         tick();
      end
      tests++;
      if (!ok || y !== exp) begin
         fails++;
         $display("FAIL bp_hold: out_valid=%b in_ready=%b y=%h, expected 1 0 %h", out_valid, in_ready, y, exp);
      end
      out_ready = 1'b1;
      tick();
      tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         fails++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_abort();
      out_ready = 1'b1;
      do_accept({52{1'b1}}, {52{1'b1}});
      for (int n = 0; n < 8; n++) tick();
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if (out_valid !== 1'b0 || y !== 103'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_async: out_valid=%b busy=%b y=%h, expected 0 0 0", out_valid, busy, y);
      end
      tick();
      rst_n = 1'b1;
      tick();
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         fails++;
         $display("FAIL abort_release: in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
      end
      test_product("abort_next", 52'h1FFF, 52'h2, 103'h3FFE);
   endtask

   task automatic test_back_to_back();
      int k;
      int lat;
      out_ready = 1'b1;
      while (!in_ready) tick();
      in_valid = 1'b1;
      a = 52'h123;
      b = 52'h5;
      tick();
      k = 0;
      while (!in_ready && k < 40) begin
         tick();
         k++;
      end
      tests++;
      if (k != 17) begin
         fails++;
         $display("FAIL b2b_gap: in_ready back after %0d cycles, expected 17", k);
      end
      a = 52'h1_0000_0000_2000;
      b = 52'h3;
      tick();
      in_valid = 1'b0;
      wait_done(lat);
      tests++;
      if (lat != 16 || y !== 103'h3_0000_0000_6000) begin
         fails++;
         $display("FAIL b2b_second: lat=%0d y=%h, expected 16 30000000006000", lat, y);
      end
      tick();
   endtask

   task automatic test_random();
      int lat;
      int stall;
      logic ok;
      logic [51:0] av;
      logic [51:0] bv;
      logic [102:0] exp;
      for (int n = 0; n < 1000; n++) begin
         av = 52'({$urandom(), $urandom()});
         bv = 52'({$urandom(), $urandom()});
         exp = clmul_ref(av, bv);
         out_ready = 1'($urandom_range(0, 1));
         do_accept(av, bv);
         out_ready = 1'($urandom_range(0, 1));
         wait_done(lat);
         out_ready = 1'b0;
         ok = (lat == 16);
         stall = $urandom_range(0, 3);
         for (int s = 0; s < stall; s++) begin
            tick();
            if (out_valid !== 1'b1 || y !== exp) ok = 1'b0;
         end
         tests++;
         if (!ok || y !== exp) begin
            fails++;
            $display("FAIL random_%0d: a=%h b=%h lat=%0d y=%h, expected %h", n, av, bv, lat, y, exp);
         end
         out_ready = 1'b1;
         tick();
      end
      out_ready = 1'b0;
   endtask

   initial begin
      logic [102:0] e_top;
      logic [102:0] e_even;
      tests = 0;
      fails = 0;
      e_top = '0;
      e_top[102] = 1'b1;
      e_even = '0;
      for (int i = 0; i < 103; i += 2) e_even[i] = 1'b1;

      test_reset();
      test_unit();
      test_product("x3", 52'h3, 52'h3, 103'h5);
      test_product("top", 52'h8_0000_0000_0000, 52'h8_0000_0000_0000, e_top);
      test_product("ones", {52{1'b1}}, {52{1'b1}}, e_even);
      test_product("cross", 52'h2000, 52'h400_0000, 103'h80_0000_0000);
      test_backpressure();
      test_reset_abort();
      test_back_to_back();
      test_random();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ca_seq_52bit.md
CA_SEQ_52BIT -- requirements
Module: ca_seq_52bit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair a/b presented.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 a  input  52  multiplicand polynomial over GF(2), bit i = coefficient of x^i.
REQ-007 b  input  52  multiplier polynomial over GF(2).
REQ-008 out_valid  output  1  y holds a complete product.
REQ-009 out_ready  input  1  consumer takes y this cycle.
REQ-010 y  output  103  carry-less product a*b over GF(2), no reduction.
REQ-011 busy  output  1  high while state is MUL or DONE.

Function
REQ-012 The block SHALL instantiate exactly one ca_13bit (13x13 carry-less, 25-bit result) and time-multiplex it over all 16 segment pairs.
REQ-013 Segments: A_i = a_reg[13i+12:13i], B_j = b_reg[13j+12:13j], i,j in 0..3.
REQ-014 FSM states SHALL be IDLE, MUL, DONE; encoding is free.
REQ-015 in_ready SHALL be 1 only in IDLE; in_valid outside IDLE SHALL be ignored.
REQ-016 IDLE->MUL on in_valid & in_ready: capture a, b into a_reg, b_reg; clear 103-bit accumulator acc; clear 4-bit counter cnt.
REQ-017 In MUL, each cycle: i = cnt[3:2], j = cnt[1:0]; acc[13(i+j)+24 : 13(i+j)] ^= ca_13bit(A_i, B_j); cnt increments.
REQ-018 Max offset 78 + 25 bits = 103; no accumulator bit SHALL be dropped or wrapped.
REQ-019 On the edge that processes cnt = 15, state SHALL go to DONE and out_valid SHALL rise.
REQ-020 Latency: out_valid SHALL be high exactly 16 cycles after the accepting edge.
REQ-021 y SHALL be driven directly from acc; y is meaningful only while out_valid = 1.
REQ-022 In DONE, y and out_valid SHALL be held stable while out_ready = 0.
REQ-023 DONE->IDLE on out_ready = 1; out_valid falls on that edge; acc is retained until the next accept.
REQ-024 No back-to-back overlap: a new accept SHALL occur no earlier than the cycle after DONE exits; throughput is 1 product per 18 cycles minimum.
REQ-025 Changes on a/b after the accept SHALL NOT affect the result.
REQ-026 out_ready while not in DONE SHALL be ignored.

Reset
REQ-027 On rst_n = 0, immediately and independent of clk: state = IDLE, acc = 0, cnt = 0, a_reg = b_reg = 0, out_valid = 0, busy = 0.
REQ-028 in_ready SHALL be 1 from the first cycle after rst_n deasserts.
REQ-029 Reset during MUL or DONE SHALL abort the operation, with no out_valid pulse; the next accepted operation SHALL produce a correct result.

Verification
REQ-030 a=1, b=1 -> y=1, out_valid exactly 16 cycles after accept, busy high for 17 cycles with out_ready tied 1.
REQ-031 a=0x3, b=0x3 -> y=0x5 (no carries); a=2^51, b=2^51 -> only y[102]=1.
REQ-032 a=b=all 52 ones -> y has every even bit 0..102 set and every odd bit clear.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE -> y and out_valid stable, in_ready=0; in_valid pulsed during MUL with other operands -> ignored, result unchanged.
REQ-034 rst_n pulsed low at MUL cycle 8 -> out_valid=0, y=0 asynchronously, in_ready=1 after release; a following a=0x1FFF, b=0x2 -> y=0x3FFE.
REQ-035 Random: 1000 random a/b pairs with random out_ready stalls -> y matches a bitwise carry-less reference model for every pair.
